// File: rtl/smallcalc_controller.sv
// Instruction sequencer for the 4 x 5-bit calculator register file.
// Walks each instruction through IDLE -> READ -> EXEC -> WRITE; LDI skips READ.
module smallcalc_controller #(
    parameter int WIDTH  = 5,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] src_a_i,
    input  logic [ADDR_W-1:0] src_b_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [WIDTH-1:0]  imm_i,
    output logic              rf_rea_o,
    output logic              rf_reb_o,
    output logic [ADDR_W-1:0] rf_raa_o,
    output logic [ADDR_W-1:0] rf_rab_o,
    input  logic [WIDTH-1:0]  rf_douta_i,
    input  logic [WIDTH-1:0]  rf_doutb_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_wa_o,
    output logic [WIDTH-1:0]  rf_din_o,
    output logic [WIDTH-1:0]  result_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              done_o
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   srcA_q, srcB_q, dst_q;
    logic [WIDTH-1:0]    imm_q;
    logic [WIDTH-1:0]    opA_q, opB_q;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                flagZ_q, flagZ_d;
    logic                flagC_q, flagC_d;
    logic [WIDTH:0]      sum, diff;
    logic                twoOp;

    // Opcodes 0..4 are the only ones that consume operand B.
    assign twoOp = (op_q <= OP_XOR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= '0;
            srcA_q   <= '0;
            srcB_q   <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            result_q <= '0;
            flagZ_q  <= 1'b0;
            flagC_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flagZ_q  <= flagZ_d;
            flagC_q  <= flagC_d;
            if (state_q == IDLE && instr_valid_i) begin
                op_q   <= op_i;
                srcA_q <= src_a_i;
                srcB_q <= src_b_i;
                dst_q  <= dst_i;
                imm_q  <= imm_i;
            end
            if (state_q == READ) begin
                opA_q <= rf_douta_i;
                opB_q <= twoOp ? rf_doutb_i : '0;
            end
        end
    end

    // Result and flags become visible in WRITE, alongside done and the RF write.
    always_comb begin
        sum      = {1'b0, opA_q} + {1'b0, opB_q};
        diff     = {1'b0, opA_q} - {1'b0, opB_q};
        result_d = result_q;
        flagZ_d  = flagZ_q;
        flagC_d  = flagC_q;
        if (state_q == EXEC) begin
            flagC_d = 1'b0;
            unique case (op_q)
                OP_ADD: begin result_d = sum[WIDTH-1:0];  flagC_d = sum[WIDTH];  end
                OP_SUB: begin result_d = diff[WIDTH-1:0]; flagC_d = diff[WIDTH]; end
                OP_AND: result_d = opA_q & opB_q;
                OP_OR:  result_d = opA_q | opB_q;
                OP_XOR: result_d = opA_q ^ opB_q;
                OP_NOT: result_d = ~opA_q;
                OP_LDI: result_d = imm_q;
                OP_MOV: result_d = opA_q;
                default: result_d = '0;
            endcase
            flagZ_d = (result_d == '0);
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        rf_rea_o      = 1'b0;
        rf_reb_o      = 1'b0;
        rf_raa_o      = '0;
        rf_rab_o      = '0;
        rf_we_o       = 1'b0;
        rf_wa_o       = '0;
        rf_din_o      = '0;
        done_o        = 1'b0;
        unique case (state_q)
            IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) state_d = (op_i == OP_LDI) ? EXEC : READ;
            end
            READ: begin
                rf_rea_o = 1'b1;
                rf_reb_o = twoOp;
                rf_raa_o = srcA_q;
                rf_rab_o = srcB_q;
                state_d  = EXEC;
            end
            EXEC: state_d = WRITE;
            WRITE: begin
                rf_we_o  = 1'b1;
                rf_wa_o  = dst_q;
                rf_din_o = result_q;
                done_o   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result_o = result_q;
    assign flag_z_o = flagZ_q;
    assign flag_c_o = flagC_q;

endmodule

// File: tb/tb_smallcalc_controller.sv
// Bench for smallcalc_controller: a bench-owned register file, a timeline model
// checked every falling edge, and directed instructions with literal expectations.
module tb_smallcalc_controller;

    logic       clk = 1'b0;
    logic       rstN;
    logic       instrValid;
    logic       instrReady;
    logic [2:0] op;
    logic [1:0] srcA, srcB, dst;
    logic [4:0] imm;
    logic       rfRea, rfReb, rfWe;
    logic [1:0] rfRaa, rfRab, rfWa;
    logic [4:0] rfDouta, rfDoutb, rfDin, result;
    logic       flagZ, flagC, done;

    int checks = 0;
    int passes = 0;

    logic [4:0] rfMem [4] = '{default: 5'd0};

    smallcalc_controller #(.WIDTH(5), .ADDR_W(2)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .instr_valid_i(instrValid), .instr_ready_o(instrReady),
        .op_i(op), .src_a_i(srcA), .src_b_i(srcB), .dst_i(dst), .imm_i(imm),
        .rf_rea_o(rfRea), .rf_reb_o(rfReb), .rf_raa_o(rfRaa), .rf_rab_o(rfRab),
        .rf_douta_i(rfDouta), .rf_doutb_i(rfDoutb),
        .rf_we_o(rfWe), .rf_wa_o(rfWa), .rf_din_o(rfDin),
        .result_o(result), .flag_z_o(flagZ), .flag_c_o(flagC), .done_o(done)
    );

    always #5 clk = ~clk;

    // Register file reads are combinational and ignore the enables on purpose.
    assign rfDouta = rfMem[rfRaa];
    assign rfDoutb = rfMem[rfRab];
    always @(posedge clk) if (rfWe) rfMem[rfWa] <= rfDin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Arithmetic reference: returns {carry, result}.
    function automatic logic [5:0] calc(input int o, input int a, input int b, input int im);
        int r, c;
        c = 0;
        case (o)
            0: begin r = (a + b) % 32; c = (a + b) > 31; end
            1: begin r = (a - b + 32) % 32; c = a < b; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 31 - a;
            6: r = im;
            default: r = a;
        endcase
        return {c[0], r[4:0]};
    endfunction

    int         ph = 0, lat = 0;
    int         mOp, mSa, mSb, mD;
    logic [4:0] mR, expRes = 0;
    logic       mC, expZ = 0, expC = 0;
    logic [4:0] mref [4] = '{default: 5'd0};

    // ph counts cycles since accept; READ shows at ph 1, WRITE at ph == lat.
    always @(negedge clk) begin
        logic rd, wr, two;
        logic [5:0] cr;
        if (!rstN) begin
            chk("resetReady", instrReady, 1);
            chk("resetRead", {rfRea, rfReb, rfRaa, rfRab}, 0);
            chk("resetWrite", {rfWe, rfWa, rfDin, done}, 0);
            chk("resetStatus", {result, flagZ, flagC}, 0);
            ph = 0; expRes = 0; expZ = 0; expC = 0;
        end else begin
            two = (mOp <= 4);
            rd  = (ph == 1) && (mOp != 6);
            wr  = (ph != 0) && (ph == lat);
            chk("ready", instrReady, ph == 0);
            chk("readPort", {rfRea, rfReb, rfRaa, rfRab},
                {rd, rd && two, rd ? mSa[1:0] : 2'd0, rd ? mSb[1:0] : 2'd0});
            chk("writePort", {rfWe, rfWa, rfDin, done},
                {wr, wr ? mD[1:0] : 2'd0, wr ? mR : 5'd0, wr});
            chk("status", {result, flagZ, flagC}, {expRes, expZ, expC});
            if (ph == 0) begin
                if (instrValid) begin
                    mOp = op; mSa = srcA; mSb = srcB; mD = dst;
                    cr  = calc(mOp, mref[mSa], mref[mSb], imm);
                    mC  = cr[5]; mR = cr[4:0];
                    lat = (mOp == 6) ? 2 : 3;
                    ph  = 1;
                end
            end else if (ph == lat) begin
                mref[mD] = mR;
                ph = 0;
            end else begin
                ph++;
                if (ph == lat) begin
                    expRes = mR; expZ = (mR == 0); expC = mC;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] d, input logic [4:0] im);
        int n = 0;
        @(posedge clk); #1;
        instrValid = 1; op = o; srcA = a; srcB = b; dst = d; imm = im;
        @(negedge clk);
        while (!instrReady && n < 10) begin @(negedge clk); n++; end
        chk("acceptReady", instrReady, 1);
        @(posedge clk); #1;
        instrValid = 0; op = $urandom; srcA = $urandom; srcB = $urandom; dst = $urandom; imm = $urandom;
    endtask

    task automatic checkOutput(input string name, input int expLat, input logic [1:0] expWa,
                               input logic [4:0] expDin, input logic expZf, input logic expCf,
                               input logic expRd, input logic expRdB);
        int   n = 0;
        logic sawRd = 0, sawRdB = 0;
        while (n < 8) begin
            @(negedge clk); n++;
            if (rfRea) sawRd = 1;
            if (rfReb) sawRdB = 1;
            if (done) break;
        end
        chk({name, ".latency"}, n, expLat);
        chk({name, ".wa"}, rfWa, expWa);
        chk({name, ".din"}, rfDin, expDin);
        chk({name, ".flags"}, {flagZ, flagC}, {expZf, expCf});
        chk({name, ".reads"}, {sawRd, sawRdB}, {expRd, expRdB});
    endtask

    typedef struct { logic [2:0] o; logic [1:0] a, b, d; logic [4:0] im; } instr_t;
    instr_t busyTab [12] = '{
        '{3'd6, 2'd0, 2'd0, 2'd1, 5'd3},  '{3'd0, 2'd1, 2'd1, 2'd2, 5'd9},
        '{3'd1, 2'd2, 2'd3, 2'd0, 5'd1},  '{3'd6, 2'd3, 2'd2, 2'd3, 5'd30},
        '{3'd4, 2'd3, 2'd0, 2'd1, 5'd7},  '{3'd2, 2'd1, 2'd3, 2'd2, 5'd0},
        '{3'd3, 2'd0, 2'd2, 2'd3, 5'd12}, '{3'd5, 2'd3, 2'd1, 2'd0, 5'd5},
        '{3'd7, 2'd2, 2'd0, 2'd1, 5'd17}, '{3'd0, 2'd3, 2'd3, 2'd2, 5'd8},
        '{3'd6, 2'd1, 2'd1, 2'd0, 5'd0},  '{3'd1, 2'd0, 2'd3, 2'd3, 5'd21}
    };

    initial begin
        rstN = 0; instrValid = 0; op = 0; srcA = 0; srcB = 0; dst = 0; imm = 0;
        repeat (2) @(posedge clk); #1 rstN = 1;

        applyStimulus(3'd6, 2'd0, 2'd0, 2'd0, 5'd7);
        checkOutput("ldi7", 2, 2'd0, 5'd7, 0, 0, 0, 0);
        applyStimulus(3'd6, 2'd0, 2'd0, 2'd1, 5'd25);
        checkOutput("ldi25", 2, 2'd1, 5'd25, 0, 0, 0, 0);
        applyStimulus(3'd0, 2'd0, 2'd1, 2'd2, 5'd0);
        checkOutput("addCarry", 3, 2'd2, 5'd0, 1, 1, 1, 1);
        applyStimulus(3'd1, 2'd0, 2'd1, 2'd3, 5'd0);
        checkOutput("subBorrow", 3, 2'd3, 5'd14, 0, 1, 1, 1);
        applyStimulus(3'd1, 2'd1, 2'd0, 2'd2, 5'd0);
        checkOutput("subNoBorrow", 3, 2'd2, 5'd18, 0, 0, 1, 1);
        applyStimulus(3'd5, 2'd0, 2'd1, 2'd0, 5'd0);
        checkOutput("notInPlace", 3, 2'd0, 5'd24, 0, 0, 1, 0);
        applyStimulus(3'd7, 2'd0, 2'd2, 2'd3, 5'd0);
        checkOutput("movRaw", 3, 2'd3, 5'd24, 0, 0, 1, 0);

        // Valid held high with fields changing every cycle; the model decides what gets accepted.
        foreach (busyTab[i]) begin
            @(posedge clk); #1;
            instrValid = 1; op = busyTab[i].o; srcA = busyTab[i].a;
            srcB = busyTab[i].b; dst = busyTab[i].d; imm = busyTab[i].im;
        end
        @(posedge clk); #1 instrValid = 0;
        repeat (5) @(posedge clk);

        applyStimulus(3'd0, 2'd0, 2'd1, 2'd2, 5'd0);
        @(posedge clk); #1 rstN = 0;
        repeat (2) @(posedge clk); #1 rstN = 1;
        repeat (3) @(posedge clk);

        applyStimulus(3'd6, 2'd0, 2'd0, 2'd1, 5'd0);
        checkOutput("ldiZero", 2, 2'd1, 5'd0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
